// File: rtl/decoder_pkg.sv
// Shared types, limits and the address range check for the pipelined one-hot decoder.
// DECODER_CONFLICT_EN selects same-cycle priority suppression and its conflict flag.
package decoder_pkg;

   localparam int CH_MAX  = 4;
   localparam int LAT_MAX = 3;

   // Per-channel flags carried alongside the one-hot vector in every stage
`ifdef DECODER_CONFLICT_EN
   typedef struct packed {
      logic valid;
      logic err;
      logic conflict;
   } ch_flags_t;
`else
   typedef struct packed {
      logic valid;
      logic err;
   } ch_flags_t;
`endif

   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned n);
      return addr < n;
   endfunction

endpackage

// File: rtl/decoder_pipe_n_dec_onehot_ch.sv
// Combinational single-channel decode: address + enable into one-hot vector,
// live flag and out-of-range error flag.
module dec_onehot_ch
   import decoder_pkg::*;
#(
   parameter int N  = 32,
   parameter int AW = $clog2(N)
) (
   input  logic [AW-1:0] i_a,
   input  logic          i_oe,
   output logic [N-1:0]  o_vec,
   output logic          o_live,
   output logic          o_err
);

   logic in_range;

   always_comb begin
      in_range = addr_in_range(32'(i_a), N);
      o_live   = i_oe && in_range;
      o_err    = i_oe && !in_range;
      o_vec    = '0;
      // Index is only used when in range, so non-power-of-two N is safe
      if (o_live) o_vec[i_a] = 1'b1;
   end

endmodule

// File: rtl/decoder_pipe_n.sv
// Registered multi-channel one-hot decoder with LAT stall/flush-aware stages.
// Define DECODER_CONFLICT_EN to let lower-index channels suppress same-address ones.
module decoder_pipe_n
   import decoder_pkg::*;
#(
   parameter int N   = 32,
   parameter int CH  = 2,
   parameter int LAT = 1,
   localparam int AW = $clog2(N)
) (
   input  logic            i_CLK,
   input  logic            i_RST,
   input  logic [CH*AW-1:0] i_A,
   input  logic [CH-1:0]   i_OE,
   input  logic            i_STALL,
   input  logic            i_FLUSH,
   output logic [CH*N-1:0] o_O,
   output logic [N-1:0]    o_ANY,
   output logic [CH-1:0]   o_VALID,
   output logic [CH-1:0]   o_ERR,
   output logic [CH-1:0]   o_CONFLICT
);

   typedef struct packed {
      logic [N-1:0] vec;
      ch_flags_t    flags;
   } ch_stage_t;

   typedef ch_stage_t [CH-1:0] stage_t;

   logic [AW-1:0] ch_addr  [CH];
   logic [N-1:0]  dec_vec  [CH];
   logic [CH-1:0] dec_live;
   logic [CH-1:0] dec_err;

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         assign ch_addr[gi] = i_A[gi*AW +: AW];

         dec_onehot_ch #(
            .N  (N),
            .AW (AW)
         ) u_dec (
            .i_a    (ch_addr[gi]),
            .i_oe   (i_OE[gi]),
            .o_vec  (dec_vec[gi]),
            .o_live (dec_live[gi]),
            .o_err  (dec_err[gi])
         );
      end
   endgenerate

   stage_t in_rec;

`ifdef DECODER_CONFLICT_EN
   logic [CH-1:0] suppress;

   always_comb begin
      suppress = '0;
      for (int k = 1; k < CH; k++) begin
         for (int j = 0; j < k; j++) begin
            if (dec_live[j] && dec_live[k] && (ch_addr[j] == ch_addr[k]))
               suppress[k] = 1'b1;
         end
      end
   end

   always_comb begin
      in_rec = '0;
      for (int k = 0; k < CH; k++) begin
         in_rec[k].vec            = suppress[k] ? '0 : dec_vec[k];
         in_rec[k].flags.valid    = dec_live[k] && !suppress[k];
         in_rec[k].flags.err      = dec_err[k];
         in_rec[k].flags.conflict = suppress[k];
      end
   end
`else
   always_comb begin
      in_rec = '0;
      for (int k = 0; k < CH; k++) begin
         in_rec[k].vec         = dec_vec[k];
         in_rec[k].flags.valid = dec_live[k];
         in_rec[k].flags.err   = dec_err[k];
      end
   end
`endif

   stage_t stage_q [LAT];
   stage_t stage_d [LAT];

   // Flush beats stall; a stall freezes the whole chain including stage 0
   always_comb begin
      stage_d = stage_q;
      if (i_FLUSH) begin
         for (int i = 0; i < LAT; i++) stage_d[i] = '0;
      end else if (!i_STALL) begin
         stage_d[0] = in_rec;
         for (int i = 1; i < LAT; i++) stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   always_comb begin
      o_O        = '0;
      o_ANY      = '0;
      o_VALID    = '0;
      o_ERR      = '0;
      o_CONFLICT = '0;
      for (int k = 0; k < CH; k++) begin
         o_O[k*N +: N] = stage_q[LAT-1][k].vec;
         o_ANY         = o_ANY | stage_q[LAT-1][k].vec;
         o_VALID[k]    = stage_q[LAT-1][k].flags.valid;
         o_ERR[k]      = stage_q[LAT-1][k].flags.err;
`ifdef DECODER_CONFLICT_EN
         o_CONFLICT[k] = stage_q[LAT-1][k].flags.conflict;
`endif
      end
   end

endmodule

// File: tb/tb_decoder_pipe_n.sv
// Self-checking bench for decoder_pipe_n (N=20, CH=3, LAT=3); honours DECODER_CONFLICT_EN.
module tb_decoder_pipe_n;

   localparam int N   = 20;
   localparam int CH  = 3;
   localparam int LAT = 3;
   localparam int AW  = $clog2(N);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst   = 1'b0;
   logic             stall = 1'b0;
   logic             flush = 1'b0;
   logic [CH*AW-1:0] a     = '0;
   logic [CH-1:0]    oe    = '0;

   logic [CH*N-1:0]  o_O;
   logic [N-1:0]     o_ANY;
   logic [CH-1:0]    o_VALID;
   logic [CH-1:0]    o_ERR;
   logic [CH-1:0]    o_CONFLICT;

   decoder_pipe_n #(
      .N   (N),
      .CH  (CH),
      .LAT (LAT)
   ) dut (
      .i_CLK      (clk),
      .i_RST      (rst),
      .i_A        (a),
      .i_OE       (oe),
      .i_STALL    (stall),
      .i_FLUSH    (flush),
      .o_O        (o_O),
      .o_ANY      (o_ANY),
      .o_VALID    (o_VALID),
      .o_ERR      (o_ERR),
      .o_CONFLICT (o_CONFLICT)
   );

   typedef struct packed {
      logic [CH*N-1:0] o;
      logic [N-1:0]    any;
      logic [CH-1:0]   valid;
      logic [CH-1:0]   err;
      logic [CH-1:0]   conf;
   } exp_t;

   // Model: each accepted input emerges after LAT accepted cycles; flush/reset empty the pipe
   exp_t exp_q[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   step_no = 0;

   function automatic exp_t ref_decode(input logic [CH*AW-1:0] aa, input logic [CH-1:0] ee);
      exp_t r;
      int   addr [CH];
      bit   taken;
      r = '0;
      for (int k = 0; k < CH; k++) addr[k] = int'(aa[k*AW +: AW]);
      for (int k = 0; k < CH; k++) begin
         if (ee[k]) begin
            if (addr[k] >= N) begin
               r.err[k] = 1'b1;
            end else begin
               taken = 1'b0;
`ifdef DECODER_CONFLICT_EN
               for (int j = 0; j < k; j++)
                  if (ee[j] && addr[j] < N && addr[j] == addr[k]) taken = 1'b1;
`endif
               if (taken) begin
                  r.conf[k] = 1'b1;
               end else begin
                  r.valid[k]         = 1'b1;
                  r.o[k*N + addr[k]] = 1'b1;
                  r.any[addr[k]]     = 1'b1;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [CH*AW-1:0] pack_a(input int a0, input int a1, input int a2);
      logic [CH*AW-1:0] v;
      v = {AW'(a2), AW'(a1), AW'(a0)};
      return v;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back('0);
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      assert (got === want)
      else begin
         n_bad++;
         $error("FAIL %s step=%0d got=%h expected=%h", tag, step_no, got, want);
      end
   endtask

   task automatic step(input logic r, input logic f, input logic s,
                       input logic [CH*AW-1:0] aa, input logic [CH-1:0] ee);
      exp_t e;
      rst = r; flush = f; stall = s; a = aa; oe = ee;
      @(posedge clk);
      if (r || f) begin
         model_clear();
      end else if (!s) begin
         exp_q.push_front(ref_decode(aa, ee));
         void'(exp_q.pop_back());
      end
      @(negedge clk);
      step_no++;
      e = exp_q[$];
      chk("o_O",        64'(o_O),        64'(e.o));
      chk("o_ANY",      64'(o_ANY),      64'(e.any));
      chk("o_VALID",    64'(o_VALID),    64'(e.valid));
      chk("o_ERR",      64'(o_ERR),      64'(e.err));
      chk("o_CONFLICT", 64'(o_CONFLICT), 64'(e.conf));
      $display("step %0d rst=%0b fl=%0b st=%0b a=%h oe=%b -> O=%h any=%h v=%b e=%b c=%b",
               step_no, r, f, s, aa, ee, o_O, o_ANY, o_VALID, o_ERR, o_CONFLICT);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic [CH*AW-1:0] ra;
      logic [CH-1:0]    re;
      logic             rr, rf, rs;

      // Reset
      step(1'b1, 1'b0, 1'b0, '0, '0);
      chk("rst_O", 64'(o_O), 64'h0);

      // ch0 address 5
      step(1'b0, 1'b0, 1'b0, pack_a(5, 0, 0), 3'b001);
      repeat (LAT-1) idle();
      chk("a5_O",   64'(o_O),   64'h20);
      chk("a5_ANY", 64'(o_ANY), 64'h20);

      // All channels on address 7
      step(1'b0, 1'b0, 1'b0, pack_a(7, 7, 7), 3'b111);
      repeat (LAT-1) idle();
`ifdef DECODER_CONFLICT_EN
      chk("conf_O",    64'(o_O),        64'h80);
      chk("conf_flag", 64'(o_CONFLICT), 64'h6);
`else
      chk("conf_O",    64'(o_O),        64'h0000_8000_0800_0080);
      chk("conf_flag", 64'(o_CONFLICT), 64'h0);
`endif

      // ch1 out of range
      step(1'b0, 1'b0, 1'b0, pack_a(0, 25, 0), 3'b010);
      repeat (LAT-1) idle();
      chk("err_flag", 64'(o_ERR),   64'h2);
      chk("err_vld",  64'(o_VALID), 64'h0);

      // Stall adds latency and ignores presented input
      step(1'b0, 1'b0, 1'b0, pack_a(3, 0, 0), 3'b001);
      step(1'b0, 1'b0, 1'b1, pack_a(9, 9, 9), 3'b111);
      step(1'b0, 1'b0, 1'b1, pack_a(9, 9, 9), 3'b111);
      repeat (LAT-2) idle();
      chk("stall_early", 64'(o_O), 64'h0);
      idle();
      chk("stall_out",   64'(o_O), 64'h8);

      // Flush together with stall clears everything
      step(1'b0, 1'b0, 1'b0, pack_a(4, 6, 8), 3'b111);
      step(1'b0, 1'b1, 1'b1, pack_a(1, 2, 3), 3'b111);
      chk("flush_O", 64'(o_O), 64'h0);
      repeat (LAT) idle();
      chk("flush_stale", 64'(o_VALID), 64'h0);

      // Reset mid-flight, then a fresh decode after LAT cycles
      step(1'b0, 1'b0, 1'b0, pack_a(2, 2, 2), 3'b111);
      step(1'b1, 1'b0, 1'b0, pack_a(2, 2, 2), 3'b111);
      chk("rst_mid_O", 64'(o_O), 64'h0);
      step(1'b0, 1'b0, 1'b0, pack_a(11, 12, 13), 3'b111);
      repeat (LAT-1) idle();
      chk("post_rst_O", 64'(o_O), 64'h0020_0001_0000_0800);

      // Randomized traffic with collision-biased addresses
      for (int t = 0; t < 400; t++) begin
         for (int k = 0; k < CH; k++) begin
            if ($urandom_range(0, 9) < 4) ra[k*AW +: AW] = AW'($urandom_range(0, 3));
            else                          ra[k*AW +: AW] = AW'($urandom_range(0, 31));
         end
         re = CH'($urandom_range(0, 7));
         rr = ($urandom_range(0, 99) < 3);
         rf = ($urandom_range(0, 99) < 5);
         rs = ($urandom_range(0, 99) < 20);
         step(rr, rf, rs, ra, re);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
